// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between a controller (master) and the bin2bcd converter (slave).
interface bin2bcd_if #(
    parameter int W = 13
);
    logic         start;
    logic [W-1:0] bin;
    logic         ready;
    logic         done_tick;
    logic [3:0]   bcd3;
    logic [3:0]   bcd2;
    logic [3:0]   bcd1;
    logic [3:0]   bcd0;

    modport master (
        output start, bin,
        input  ready, done_tick, bcd3, bcd2, bcd1, bcd0
    );

    modport slave (
        input  start, bin,
        output ready, done_tick, bcd3, bcd2, bcd1, bcd0
    );
endinterface

// File: rtl/bin2bcd.sv
// Iterative W-bit binary to 4-digit BCD converter (shift-and-add-3), one bit per clock.
module bin2bcd #(
    parameter int W = 13
) (
    input logic     clk,
    input logic     reset,
    bin2bcd_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

    state_t        state_q;
    logic [W-1:0]  p2s_q, p2s_d;
    logic [CW-1:0] n_q;
    logic [3:0]    bcd3_q, bcd2_q, bcd1_q, bcd0_q;
    logic [3:0]    bcd3_d, bcd2_d, bcd1_d, bcd0_d;
    logic          ready_q, doneTick_q;
    logic [15+W:0] shiftVec;

    function automatic logic [3:0] adjustDigit(input logic [3:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

    // The bcd3 MSB falls off the top; it can never be set for W <= 13.
    always_comb begin
        shiftVec = {adjustDigit(bcd3_q), adjustDigit(bcd2_q),
                    adjustDigit(bcd1_q), adjustDigit(bcd0_q), p2s_q, 1'b0};
        bcd3_d = shiftVec[15+W:12+W];
        bcd2_d = shiftVec[11+W:8+W];
        bcd1_d = shiftVec[7+W:4+W];
        bcd0_d = shiftVec[3+W:W];
        p2s_d  = shiftVec[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            p2s_q      <= '0;
            n_q        <= '0;
            bcd3_q     <= 4'd0;
            bcd2_q     <= 4'd0;
            bcd1_q     <= 4'd0;
            bcd0_q     <= 4'd0;
            ready_q    <= 1'b1;
            doneTick_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        p2s_q   <= bus.bin;
                        n_q     <= CW'(W);
                        bcd3_q  <= 4'd0;
                        bcd2_q  <= 4'd0;
                        bcd1_q  <= 4'd0;
                        bcd0_q  <= 4'd0;
                        ready_q <= 1'b0;
                        state_q <= OP;
                    end
                end
                OP: begin
                    p2s_q  <= p2s_d;
                    bcd3_q <= bcd3_d;
                    bcd2_q <= bcd2_d;
                    bcd1_q <= bcd1_d;
                    bcd0_q <= bcd0_d;
                    n_q    <= n_q - CW'(1);
                    if (n_q == CW'(1)) begin
                        doneTick_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    doneTick_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    doneTick_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done_tick = doneTick_q;
    assign bus.bcd3      = bcd3_q;
    assign bus.bcd2      = bcd2_q;
    assign bus.bcd1      = bcd1_q;
    assign bus.bcd0      = bcd0_q;
endmodule
